gait_sequencer: RTL and testbench

GAIT_SEQUENCER -- requirements
Module: gait_sequencer

---
 rtl/gait_pkg.sv | 32 +++
 rtl/gait_sequencer_step_prescaler.sv | 41 ++++
 rtl/gait_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_gait_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gait_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gait_pkg
//  Brief    : Shared state encoding, gait codes and defaults for the gait
//             sequencer block.
//  Revision : 1.0  initial release
// ============================================================================
package gait_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOMING   = 3'd1,
        ST_STAND    = 3'd2,
        ST_RUN      = 3'd3,
        ST_STOPPING = 3'd4
    } gait_state_t;

    localparam logic [2:0] c_gait_stop  = 3'd0;
    localparam logic [2:0] c_gait_fwd   = 3'd1;
    localparam logic [2:0] c_gait_back  = 3'd2;
    localparam logic [2:0] c_gait_left  = 3'd3;
    localparam logic [2:0] c_gait_right = 3'd4;

    localparam int c_default_steps = 64;

    // Codes 5..7 are not gaits and behave like STOP.
    function automatic logic is_motion_gait(input logic [2:0] code);
        return (code >= c_gait_fwd) && (code <= c_gait_right);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gait_sequencer_step_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : step_prescaler
//  Brief    : Divides clk down to the step rate; period is TICK_DIV >> rate,
//             with rate sampled only when the period restarts.
//  Revision : 1.0  initial release
// ============================================================================
module step_prescaler #(
    parameter int TICK_DIV = 300000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] rate,
    output logic       tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_limit;
    logic [CW-1:0] w_reload;

    assign w_reload = CW'((TICK_DIV >> rate) - 1);
    assign tick     = !clear && (r_count == r_limit);

    // The limit is latched on reload so a rate change only affects the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_limit <= CW'(TICK_DIV - 1);
        end else if (clear || tick) begin
            r_count <= '0;
            r_limit <= w_reload;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gait_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gait_sequencer
//  Brief    : Walk sequencer: homing hold, stand, gait ROM address stepping
//             with cycle-boundary gait changes and emergency halt.
//  Revision : 1.0  initial release
// ============================================================================
module gait_sequencer
    import gait_pkg::*;
#(
    parameter int TICK_DIV    = 300000,
    parameter int STEPS       = c_default_steps,
    parameter int HOME_CYCLES = 84000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_gait,
    input  logic [1:0] rate,
    output logic       cmd_ready,
    output logic [7:0] step_addr,
    output logic [2:0] gait_sel,
    output logic       servo_en,
    output logic       step_tick,
    output logic       cycle_done,
    output logic       busy
);

    localparam int             HW          = $clog2(HOME_CYCLES + 1);
    localparam logic [HW-1:0]  c_home_last = HW'(HOME_CYCLES - 1);
    localparam logic [7:0]     c_addr_last = 8'(STEPS - 1);

    gait_state_t   r_state,      w_state_nxt;
    logic [HW-1:0] r_home_cnt,   w_home_nxt;
    logic [7:0]    r_step_addr,  w_addr_nxt;
    logic [2:0]    r_gait_sel,   w_gait_nxt;
    logic          r_pend_valid, w_pend_valid_nxt;
    logic [2:0]    r_pend_gait,  w_pend_gait_nxt;
    logic          r_step_tick,  w_tick_nxt;
    logic          r_cycle_done, w_done_nxt;
    logic          r_start_d;

    logic w_start_rise;
    logic w_xfer;
    logic w_consume;
    logic w_pre_clear;
    logic w_pre_tick;
    logic w_addr_last;

    step_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_pre_clear),
        .rate  (rate),
        .tick  (w_pre_tick)
    );

    assign w_start_rise = start && !r_start_d;
    assign w_xfer       = cmd_valid && !r_pend_valid && !halt;
    assign w_addr_last  = (r_step_addr == c_addr_last);

    always_comb begin
        w_state_nxt      = r_state;
        w_home_nxt       = r_home_cnt;
        w_addr_nxt       = r_step_addr;
        w_gait_nxt       = r_gait_sel;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_gait_nxt  = r_pend_gait;
        w_tick_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_consume        = 1'b0;
        w_pre_clear      = 1'b1;

        if (w_xfer) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_gait_nxt  = cmd_gait;
        end

        case (r_state)
            ST_IDLE: begin
                w_addr_nxt = '0;
                w_gait_nxt = c_gait_stop;
                if (w_start_rise) begin
                    w_state_nxt = ST_HOMING;
                    w_home_nxt  = '0;
                end
            end
            ST_HOMING: begin
                if (r_home_cnt == c_home_last) begin
                    w_state_nxt = ST_STAND;
                end else begin
                    w_home_nxt = r_home_cnt + HW'(1);
                end
            end
            ST_STAND: begin
                w_addr_nxt = '0;
                if (r_pend_valid) begin
                    w_consume = 1'b1;
                    if (is_motion_gait(r_pend_gait)) begin
                        w_state_nxt = ST_RUN;
                        w_gait_nxt  = r_pend_gait;
                    end
                end
            end
            ST_RUN, ST_STOPPING: begin
                w_pre_clear = 1'b0;
                if (w_pre_tick) begin
                    w_tick_nxt = 1'b1;
                    w_done_nxt = w_addr_last;
                    w_addr_nxt = w_addr_last ? 8'd0 : r_step_addr + 8'd1;
                end
                if (r_state == ST_RUN) begin
                    if (w_pre_tick && w_addr_last) begin
                        // Cycle boundary: the only point where the gait may change.
                        if (r_pend_valid) begin
                            w_consume = 1'b1;
                            if (is_motion_gait(r_pend_gait)) begin
                                w_gait_nxt = r_pend_gait;
                            end else begin
                                w_state_nxt = ST_STAND;
                                w_gait_nxt  = c_gait_stop;
                            end
                        end
                    end else if (r_pend_valid && !is_motion_gait(r_pend_gait)) begin
                        // A stop mid-cycle finishes the cycle first so the legs end at home pose.
                        w_consume   = 1'b1;
                        w_state_nxt = ((r_step_addr == 8'd0) && !w_pre_tick) ? ST_STAND : ST_STOPPING;
                    end
                end else if (w_pre_tick && w_addr_last) begin
                    w_state_nxt = ST_STAND;
                    w_gait_nxt  = c_gait_stop;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_consume) begin
            w_pend_valid_nxt = 1'b0;
        end

        if (halt) begin
            w_state_nxt      = ST_IDLE;
            w_home_nxt       = '0;
            w_addr_nxt       = '0;
            w_gait_nxt       = c_gait_stop;
            w_pend_valid_nxt = 1'b0;
            w_tick_nxt       = 1'b0;
            w_done_nxt       = 1'b0;
            w_pre_clear      = 1'b1;
        end
    end

    // Edge detector resets high so a start level held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_home_cnt   <= '0;
            r_step_addr  <= '0;
            r_gait_sel   <= c_gait_stop;
            r_pend_valid <= 1'b0;
            r_pend_gait  <= c_gait_stop;
            r_step_tick  <= 1'b0;
            r_cycle_done <= 1'b0;
            r_start_d    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_home_cnt   <= w_home_nxt;
            r_step_addr  <= w_addr_nxt;
            r_gait_sel   <= w_gait_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_gait  <= w_pend_gait_nxt;
            r_step_tick  <= w_tick_nxt;
            r_cycle_done <= w_done_nxt;
            r_start_d    <= start;
        end
    end

    assign cmd_ready  = !r_pend_valid;
    assign step_addr  = r_step_addr;
    assign gait_sel   = r_gait_sel;
    assign servo_en   = (r_state == ST_STAND) || (r_state == ST_RUN) || (r_state == ST_STOPPING);
    assign step_tick  = r_step_tick;
    assign cycle_done = r_cycle_done;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gait_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gait_sequencer
//  Brief    : Self-checking bench for gait_sequencer (TICK_DIV=8, STEPS=8,
//             HOME_CYCLES=10) with a tick scoreboard and a gait vector table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gait_sequencer;
    import gait_pkg::*;

    localparam int TICK_DIV    = 8;
    localparam int STEPS       = 8;
    localparam int HOME_CYCLES = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_gait = 3'd0;
    logic [1:0] rate = 2'd0;
    logic       cmd_ready;
    logic [7:0] step_addr;
    logic [2:0] gait_sel;
    logic       servo_en;
    logic       step_tick;
    logic       cycle_done;
    logic       busy;

    gait_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .STEPS       (STEPS),
        .HOME_CYCLES (HOME_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .cmd_valid  (cmd_valid),
        .cmd_gait   (cmd_gait),
        .rate       (rate),
        .cmd_ready  (cmd_ready),
        .step_addr  (step_addr),
        .gait_sel   (gait_sel),
        .servo_en   (servo_en),
        .step_tick  (step_tick),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       done;
        logic [2:0] gait;
        logic       chk_gait;
        int         period;
    } tick_exp_t;

    typedef struct {
        logic [2:0] gait;
        logic [1:0] rate;
        logic [2:0] exp_gait;
        int         period;
        logic       runs;
    } gait_rec_t;

    tick_exp_t sb[$];
    gait_rec_t tbl[6];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input logic [7:0] a, input logic d, input logic [2:0] g,
                             input logic cg, input int p);
        tick_exp_t e;
        e.addr = a; e.done = d; e.gait = g; e.chk_gait = cg; e.period = p;
        sb.push_back(e);
    endtask

    // One full gait cycle: addresses 1..STEPS-1 then the wrap to 0.
    task automatic push_cycle(input logic [2:0] g, input logic [2:0] wrap_g, input logic chk_wrap,
                              input int first_p, input int p);
        for (int a = 1; a <= STEPS; a++) begin
            if (a == STEPS) push_tick(8'd0, 1'b1, wrap_g, chk_wrap, p);
            else            push_tick(8'(a), 1'b0, g, 1'b1, (a == 1) ? first_p : p);
        end
    endtask

    task automatic send_cmd(input logic [2:0] g);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_gait  = g;
        while (!cmd_ready && n < 100) begin
            step(1);
            n++;
        end
        check("cmd_accept_ready", cmd_ready, 1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pos(input logic [2:0] g, input logic [7:0] a, input string name);
        int n = 0;
        while (!(gait_sel == g && step_addr == a) && n < 200) begin
            step(1);
            n++;
        end
        check(name, {31'd0, (gait_sel == g && step_addr == a)}, 1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        tick_exp_t e;
        int last_tick = 0;
        forever begin
            @(negedge clk);
            if (step_tick) begin
                if (sb.size() == 0) begin
                    check("tick_unexpected", step_tick, 0);
                end else begin
                    e = sb.pop_front();
                    check("tick_addr", step_addr, e.addr);
                    check("tick_cycle_done", cycle_done, e.done);
                    if (e.chk_gait) check("tick_gait_sel", gait_sel, e.gait);
                    if (e.period != 0) check("tick_period", cyc - last_tick, e.period);
                end
                last_tick = cyc;
            end else if (cycle_done) begin
                check("done_without_tick", cycle_done, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{3'd1, 2'd0, 3'd1, 8, 1'b1};
        tbl[1] = '{3'd2, 2'd1, 3'd2, 4, 1'b1};
        tbl[2] = '{3'd7, 2'd0, 3'd0, 0, 1'b0};
        tbl[3] = '{3'd4, 2'd2, 3'd4, 2, 1'b1};
        tbl[4] = '{3'd0, 2'd0, 3'd0, 0, 1'b0};
        tbl[5] = '{3'd3, 2'd3, 3'd3, 1, 1'b1};

        // Reset with start held high
        start = 1'b1;
        #23;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_step_addr", step_addr, 0);
        check("rst_gait_sel", gait_sel, 0);
        check("rst_servo_en", servo_en, 0);
        check("rst_step_tick", step_tick, 0);
        check("rst_cycle_done", cycle_done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("start_held_from_reset", busy, 0);

        // Power-up homing
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("homing_busy", busy, 1);
        check("homing_servo_first", servo_en, 0);
        for (int i = 0; i < HOME_CYCLES - 1; i++) begin
            step(1);
            check("homing_servo_held", servo_en, 0);
        end
        step(1);
        check("stand_servo_en", servo_en, 1);
        check("stand_step_addr", step_addr, 0);
        check("stand_busy", busy, 1);

        // Gait vector table, each run stopped mid-cycle
        for (int r = 0; r < 6; r++) begin
            rate = tbl[r].rate;
            if (tbl[r].runs) push_cycle(tbl[r].exp_gait, 3'd0, 1'b0, 0, tbl[r].period);
            send_cmd(tbl[r].gait);
            if (tbl[r].runs) begin
                wait_pos(tbl[r].exp_gait, 8'd1, "table_reach_addr1");
                send_cmd(c_gait_stop);
                wait_empty();
                step(4);
            end else begin
                step(12);
                check("table_idle_ready", cmd_ready, 1);
            end
            check("table_end_addr", step_addr, 0);
            check("table_end_servo", servo_en, 1);
            check("table_end_busy", busy, 1);
        end

        // Gait change queued mid-cycle, second offer blocked until wrap, then stop at 5
        rate = 2'd0;
        push_cycle(c_gait_fwd, c_gait_left, 1'b1, 0, 8);
        push_cycle(c_gait_left, c_gait_back, 1'b1, 8, 8);
        push_cycle(c_gait_back, c_gait_stop, 1'b0, 8, 8);
        send_cmd(c_gait_fwd);
        wait_pos(c_gait_fwd, 8'd3, "fwd_reach_addr3");
        send_cmd(c_gait_left);
        check("pending_full_ready", cmd_ready, 0);
        check("gait_held_mid_cycle", gait_sel, c_gait_fwd);
        begin
            int n = 0;
            cmd_valid = 1'b1;
            cmd_gait  = c_gait_back;
            while (!cmd_ready && n < 100) begin
                step(1);
                n++;
            end
        end
        check("ready_reopen_addr", step_addr, 0);
        check("ready_reopen_gait", gait_sel, c_gait_left);
        check("ready_reopen_done", cycle_done, 1);
        step(1);
        cmd_valid = 1'b0;
        check("second_cmd_pending", cmd_ready, 0);
        wait_pos(c_gait_back, 8'd5, "back_reach_addr5");
        send_cmd(c_gait_stop);
        wait_empty();
        step(16);
        check("stop_stand_servo", servo_en, 1);
        check("stop_stand_addr", step_addr, 0);
        check("stop_stand_busy", busy, 1);

        // Rate change in RUN, then halt at step 4 against a pending cmd and a due tick
        push_tick(8'd1, 1'b0, c_gait_fwd, 1'b1, 0);
        push_tick(8'd2, 1'b0, c_gait_fwd, 1'b1, 8);
        push_tick(8'd3, 1'b0, c_gait_fwd, 1'b1, 2);
        push_tick(8'd4, 1'b0, c_gait_fwd, 1'b1, 2);
        send_cmd(c_gait_fwd);
        wait_pos(c_gait_fwd, 8'd1, "rate_reach_addr1");
        rate = 2'd2;
        wait_pos(c_gait_fwd, 8'd4, "rate_reach_addr4");
        send_cmd(c_gait_right);
        halt = 1'b1;
        step(1);
        check("halt_busy", busy, 0);
        check("halt_servo_en", servo_en, 0);
        check("halt_step_addr", step_addr, 0);
        check("halt_gait_sel", gait_sel, 0);
        check("halt_step_tick", step_tick, 0);
        check("halt_pending_cleared", cmd_ready, 1);
        check("halt_scoreboard_empty", sb.size(), 0);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        check("start_during_halt", busy, 0);
        halt = 1'b0;
        step(1);
        check("start_level_after_halt", busy, 0);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        check("restart_homing", busy, 1);

        // Asynchronous reset mid-homing
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_step_addr", step_addr, 0);
        check("arst_gait_sel", gait_sel, 0);
        check("arst_servo_en", servo_en, 0);
        check("arst_step_tick", step_tick, 0);
        check("arst_cycle_done", cycle_done, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
